// File: rtl/slc3_pkg.sv
// Shared types and defaults for the SLC-3 memory/I-O bridge.
package slc3_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone
  } bridge_state_t;

  localparam logic [19:0] IoAddrDefault     = 20'h0FFFF;
  localparam int unsigned WaitCyclesDefault = 2;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchronizer for the asynchronous board switches.
module sw_sync #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-to-async-SRAM bridge with one memory-mapped switch/hex I/O register.
// Define SLC3_SW_SYNC_EN to pass SW through a two-flop synchronizer.
module mem_io_bridge
  import slc3_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault,
  parameter logic [19:0] IO_ADDR     = IoAddrDefault
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] Data,
  input  logic [15:0] SW,
  output logic [15:0] HEX
);

  localparam logic [3:0] AccessLast = 4'(WAIT_CYCLES - 1);

  bridge_state_t state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [15:0]   wdata_q, rdata_q, hex_q;
  logic [19:0]   sram_addr_q;
  logic          ce_q, lane_q, oe_q, mem_we_q, data_oe_q;
  logic          ack_q, busy_q;
  logic [15:0]   sw_val;

`ifdef SLC3_SW_SYNC_EN
  sw_sync #(
    .Width (16)
  ) u_sw_sync (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .d_i    (SW),
    .q_o    (sw_val)
  );
`else
  assign sw_val = SW;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      hex_q       <= '0;
      sram_addr_q <= '0;
      ce_q        <= 1'b1;
      lane_q      <= 1'b1;
      oe_q        <= 1'b1;
      mem_we_q    <= 1'b1;
      data_oe_q   <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (addr == IO_ADDR) begin
              // I/O register completes in one cycle and never touches the SRAM strobes
              if (we) hex_q <= wdata;
              else    rdata_q <= sw_val;
              ack_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              ce_q        <= 1'b0;
              lane_q      <= 1'b0;
              oe_q        <= we;
              mem_we_q    <= 1'b1;
              sram_addr_q <= addr;
              state_q     <= StSetup;
            end
          end
        end
        StSetup: begin
          cnt_q     <= AccessLast;
          mem_we_q  <= ~we_q;
          data_oe_q <= we_q;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            // WE rises into DONE while data stays driven for hold time
            mem_we_q <= 1'b1;
            ack_q    <= 1'b1;
            if (!we_q) rdata_q <= Data;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          ce_q      <= 1'b1;
          lane_q    <= 1'b1;
          oe_q      <= 1'b1;
          mem_we_q  <= 1'b1;
          data_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Data      = data_oe_q ? wdata_q : 'z;
  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign Mem_CE    = ce_q;
  assign Mem_UB    = lane_q;
  assign Mem_LB    = lane_q;
  assign Mem_OE    = oe_q;
  assign Mem_WE    = mem_we_q;
  assign SRAM_ADDR = sram_addr_q;
  assign HEX       = hex_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed scoreboard bench for mem_io_bridge with a small async SRAM model.
module tb_mem_io_bridge;

  localparam int unsigned W = 2;
  localparam logic [19:0] IoAddr = 20'h0FFFF;

  typedef struct {
    logic        w;
    logic        io;
    logic [15:0] data;
    int          lat;
  } xfer_t;

  logic        Clk, Reset, req, we;
  logic [19:0] addr;
  logic [15:0] wdata, SW;
  logic [15:0] rdata, HEX;
  logic        ack, busy, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] Data;
  logic [15:0] model_val;
  logic        tb_force;

  int tests = 0;
  int fails = 0;
  xfer_t sb_q[$];

  mem_io_bridge #(
    .WAIT_CYCLES (W),
    .IO_ADDR     (IoAddr)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .busy      (busy),
    .Mem_CE    (Mem_CE),
    .Mem_UB    (Mem_UB),
    .Mem_LB    (Mem_LB),
    .Mem_OE    (Mem_OE),
    .Mem_WE    (Mem_WE),
    .SRAM_ADDR (SRAM_ADDR),
    .Data      (Data),
    .SW        (SW),
    .HEX       (HEX)
  );

  // Read-only SRAM model; tb_force lets the bench prove the DUT is not driving
  assign model_val = (SRAM_ADDR == 20'h00010) ? 16'h1234 :
                     (SRAM_ADDR == 20'h00030) ? 16'hC0DE : 16'h0BAD;
  assign Data = (!Mem_CE && !Mem_OE && Mem_WE) ? model_val :
                (tb_force ? 16'h0000 : 16'hzzzz);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic score(input int rel);
    xfer_t t;
    check("sb_nonempty", (sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      check("ack_latency", rel, t.lat);
      if (!t.w) check("rdata", rdata, t.data);
      else if (t.io) check("hex", HEX, t.data);
    end
  endtask

  task automatic check_cycle(input logic w, input logic io, input int c,
                             input logic [19:0] a, input logic [15:0] d);
    check("busy", busy, 1);
    if (io) begin
      check("io_ce", Mem_CE, 1);
      check("io_ack", ack, (c == 1));
    end else begin
      check("ce", Mem_CE, 0);
      check("ub_lb", {Mem_UB, Mem_LB}, 2'b00);
      check("oe", Mem_OE, w);
      check("mem_we", Mem_WE, !(w && c >= 2 && c <= W + 1));
      check("ack", ack, (c == W + 2));
      check("sram_addr", SRAM_ADDR, a);
      if (w && c >= 2) check("data_wr", Data, d);
      if (!w) check("data_rd", Data, d);
    end
  endtask

  // Drives one request for a single edge, then follows it to ack
  task automatic run_xfer(input logic w, input logic [19:0] a, input logic [15:0] wd,
                          input logic [15:0] rd_exp, input bit strobes);
    xfer_t t;
    bit got;
    t.w = w;
    t.io = (a == IoAddr);
    t.data = w ? wd : rd_exp;
    t.lat = t.io ? 1 : int'(W) + 2;
    sb_q.push_back(t);
    req = 1'b1; we = w; addr = a; wdata = wd;
    tick();
    req = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (strobes) check_cycle(w, t.io, c, a, w ? wd : rd_exp);
      if (ack) begin
        score(c);
        got = 1'b1;
      end else begin
        tick();
      end
    end
    check("ack_seen", got, 1);
    tick();
    check("busy_after", busy, 0);
    check("ack_single", ack, 0);
  endtask

  initial begin
    int  nacks;
    bit  saw_ack;
    Reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; SW = 16'h00A5;
    tb_force = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}, 5'b11111);
    check("rst_ack_busy", {ack, busy}, 2'b00);
    check("rst_rdata", rdata, 0);
    check("rst_hex", HEX, 0);
    check("rst_sram_addr", SRAM_ADDR, 0);
    tb_force = 1'b1; #1;
    check("rst_data_z", Data, 16'h0000);
    tb_force = 1'b0;
    tick();
    Reset = 1'b1;
    tick();

    // SRAM read, then SRAM write, then I/O read and write
    run_xfer(1'b0, 20'h00010, 16'h5A5A, 16'h1234, 1'b1);
    run_xfer(1'b1, 20'h00010, 16'hBEEF, 16'h0000, 1'b1);
    run_xfer(1'b0, IoAddr, 16'h0000, 16'h00A5, 1'b1);
    check("rdata_hold", rdata, 16'h00A5);
    run_xfer(1'b1, IoAddr, 16'h0042, 16'h0000, 1'b1);
    check("hex_hold", HEX, 16'h0042);

    // Back-to-back: req held high across edges 0..9
    sb_q.push_back('{w: 1'b1, io: 1'b0, data: 16'h7777, lat: 4});
    sb_q.push_back('{w: 1'b1, io: 1'b0, data: 16'h7777, lat: 9});
    req = 1'b1; we = 1'b1; addr = 20'h00040; wdata = 16'h7777;
    tick();
    nacks = 0;
    for (int rel = 1; rel <= 16; rel++) begin
      if (ack) begin
        score(rel);
        nacks++;
      end
      if (rel == 9) req = 1'b0;
      tick();
    end
    check("b2b_acks", nacks, 2);
    check("b2b_idle", busy, 0);

    // Reset pulsed in the middle of a write's ACCESS phase
    req = 1'b1; we = 1'b1; addr = 20'h00020; wdata = 16'h5555;
    tick();
    req = 1'b0;
    tick();
    check("abort_we_low", Mem_WE, 0);
    check("abort_data", Data, 16'h5555);
    #2 Reset = 1'b0;
    #1;
    check("abort_we_high", Mem_WE, 1);
    check("abort_ce", Mem_CE, 1);
    check("abort_busy", busy, 0);
    check("abort_hex", HEX, 0);
    tb_force = 1'b1; #1;
    check("abort_data_z", Data, 16'h0000);
    tb_force = 1'b0;
    #3 Reset = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack) saw_ack = 1'b1;
    end
    check("abort_no_ack", saw_ack, 0);
    run_xfer(1'b0, 20'h00030, 16'h0000, 16'hC0DE, 1'b1);

`ifdef SLC3_SW_SYNC_EN
    // SW seen through the synchronizer lags by two cycles
    SW = 16'h0000;
    tick(); tick(); tick();
    SW = 16'hFFFF;
    tick();
    run_xfer(1'b0, IoAddr, 16'h0000, 16'h0000, 1'b0);
    run_xfer(1'b0, IoAddr, 16'h0000, 16'hFFFF, 1'b0);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of ACCESS cycles per SRAM transfer; legal range 1..15.
REQ-002 Parameter IO_ADDR, default 20'h0FFFF: address decoded as the switch/hex I/O register instead of SRAM.
REQ-003 Clk  input  1  single system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  CPU access request; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  20  CPU word address; sampled with req.
REQ-008 wdata  input  16  write data; sampled with req.
REQ-009 rdata  output  16  read data; registered; valid from ack onward until the next read completes.
REQ-010 ack  output  1  single-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  active-low SRAM strobes.
REQ-013 SRAM_ADDR  output  20  registered SRAM address.
REQ-014 Data  inout  16  SRAM data bus; driven only during writes, high-Z otherwise.
REQ-015 SW  input  16  board switches; the I/O read source.
REQ-016 HEX  output  16  hex-display register; the I/O write target.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS, DONE.
REQ-018 IDLE: on req=1, latch we, addr and wdata. If addr==IO_ADDR, go to DONE; otherwise go to SETUP.
REQ-019 IDLE: req=0 stays IDLE.
REQ-020 I/O read: at the IDLE->DONE edge, load rdata with the switch value.
REQ-021 I/O write: at the IDLE->DONE edge, load HEX with wdata. I/O accesses never assert Mem_CE.
REQ-022 SETUP lasts exactly 1 cycle.
  - Mem_CE=UB=LB=0.
  - Mem_OE=0 if read.
  - SRAM_ADDR=latched addr.
  - Mem_WE=1.
REQ-023 ACCESS lasts exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
  - Mem_WE=0 for writes.
  - Data=latched wdata for writes.
  - CE, UB, LB and OE are held as in SETUP.
REQ-024 Last ACCESS cycle of a read: capture Data into rdata.
REQ-025 DONE lasts 1 cycle.
  - ack=1 and Mem_WE=1.
  - Mem_CE and Mem_OE are held for that cycle; write data stays driven for that cycle (hold time).
  - Then return to IDLE.
REQ-026 Latency, with req sampled at edge N:
  - SRAM access: ack high in cycle N+2+WAIT_CYCLES.
  - I/O access: ack high in cycle N+1.
REQ-027 req is ignored in SETUP, ACCESS and DONE. A req held high through DONE is accepted at the first IDLE edge (one idle cycle between transfers).
REQ-028 Data is never driven in the same cycle that Mem_OE=0.
REQ-029 All strobes are registered outputs; none is combinationally derived from req.

Reset
REQ-030 Reset low immediately (asynchronously) forces:
  - state IDLE;
  - Mem_CE, UB, LB, OE, WE = 1;
  - Data high-Z;
  - ack=0, busy=0;
  - rdata=0, HEX=0, SRAM_ADDR=0;
  - counter=0.
REQ-031 Reset asserted mid-transfer aborts the transfer with no ack. The first req after deassertion starts a fresh transfer.

Configuration
REQ-032 With SLC3_SW_SYNC_EN defined, SW passes through a two-flop synchronizer (reset value 0) before the I/O read mux. The value seen is SW from 2 cycles earlier.
REQ-033 Without SLC3_SW_SYNC_EN, SW feeds the I/O read mux directly.

Structure
REQ-034 Package slc3_pkg holds:
  - the FSM state enum bridge_state_t;
  - the IO_ADDR default constant;
  - the WAIT_CYCLES default constant.
REQ-035 One sub-module, sw_sync (two-flop synchronizer, 16 bits), is instantiated only under SLC3_SW_SYNC_EN. All else is inline in mem_io_bridge.

Verification
REQ-036 SRAM write, WAIT_CYCLES=2: req=1, we=1, addr=20'h00010, wdata=16'hBEEF at edge 0.
  - Mem_WE=0 in cycles 2-3.
  - Data=BEEF in cycles 2-4.
  - ack in cycle 4; busy cycles 1-4.
REQ-037 SRAM read: model returns 16'h1234 at 20'h00010; req read at edge 0.
  - Mem_OE=0 in cycles 1-4.
  - rdata=1234 when ack pulses in cycle 4.
  - Data never driven by the DUT.
REQ-038 I/O: SW=16'h00A5, read 20'h0FFFF gives rdata=00A5 with ack 1 cycle later and Mem_CE=1 throughout. A write of 16'h0042 to 20'h0FFFF gives HEX=0042.
REQ-039 Back-to-back: req held high for 10 cycles gives exactly two SRAM transfers, acks in cycles 4 and 9.
REQ-040 Reset pulsed low in the middle of ACCESS of a write:
  - Mem_WE returns to 1 and Data goes high-Z within the same cycle.
  - No ack; HEX=0.
  - The next read completes normally.
REQ-041 SLC3_SW_SYNC_EN defined: SW changes 0000->FFFF at edge 0; an I/O read sampled at edge 1 returns 0000, and one sampled at edge 3 returns FFFF.
